// File: rtl/dlsc_axi_router_wr_scheduler_if.sv
// W-channel and command bundle between the router command stage, the input
// ports and the output ports of the write-data scheduler.
interface dlsc_axi_router_wr_scheduler_if #(
    parameter int DATA     = 32,
    parameter int STRB     = DATA/8,
    parameter int LEN      = 4,
    parameter int INPUTS   = 1,
    parameter int INPUTSB  = 1,
    parameter int OUTPUTS  = 1,
    parameter int OUTPUTSB = 1
);
    // Handshake: a beat moves on a port in any cycle where both its valid and
    // ready are 1; valid may be raised without waiting for ready, and data,
    // strb and last are held stable while valid=1 and ready=0.
    logic                      cmd_push;
    logic [INPUTSB-1:0]        cmd_input;
    logic [OUTPUTSB-1:0]       cmd_output;
    logic [LEN-1:0]            cmd_len;
    logic                      cmd_full;

    logic [INPUTS-1:0]         in_ready;
    logic [INPUTS-1:0]         in_valid;
    logic [INPUTS-1:0]         in_last;
    logic [INPUTS*DATA-1:0]    in_data;
    logic [INPUTS*STRB-1:0]    in_strb;

    logic [OUTPUTS-1:0]        out_ready;
    logic [OUTPUTS-1:0]        out_valid;
    logic [OUTPUTS-1:0]        out_last;
    logic [OUTPUTS*DATA-1:0]   out_data;
    logic [OUTPUTS*STRB-1:0]   out_strb;

    logic                      err_overflow;
    logic                      err_last;
    logic                      dbg_state;

    modport slave (
        input  cmd_push, cmd_input, cmd_output, cmd_len,
        input  in_valid, in_last, in_data, in_strb,
        input  out_ready,
        output cmd_full, in_ready,
        output out_valid, out_last, out_data, out_strb,
        output err_overflow, err_last, dbg_state
    );

    modport master (
        output cmd_push, cmd_input, cmd_output, cmd_len,
        output in_valid, in_last, in_data, in_strb,
        output out_ready,
        input  cmd_full, in_ready,
        input  out_valid, out_last, out_data, out_strb,
        input  err_overflow, err_last, dbg_state
    );
endinterface

// File: rtl/dlsc_axi_router_wr_scheduler.sv
// Queues routing commands in issue order and steers W beats from the chosen
// input to the chosen output one burst at a time, regenerating WLAST.
module dlsc_axi_router_wr_scheduler #(
    parameter int DATA     = 32,
    parameter int STRB     = DATA/8,
    parameter int LEN      = 4,
    parameter int INPUTS   = 1,
    parameter int INPUTSB  = 1,
    parameter int OUTPUTS  = 1,
    parameter int OUTPUTSB = 1,
    parameter int DEPTH    = 16,
    parameter int DEPTHB   = 4
) (
    input  logic clk,
    input  logic rst,
    dlsc_axi_router_wr_scheduler_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [INPUTSB-1:0]   q_in  [DEPTH];
    logic [OUTPUTSB-1:0]  q_out [DEPTH];
    logic [LEN-1:0]       q_len [DEPTH];
    logic [DEPTHB-1:0]    wr_ptr;
    logic [DEPTHB-1:0]    rd_ptr;
    logic [DEPTHB:0]      count;

    logic [INPUTSB-1:0]   sel_in;
    logic [OUTPUTSB-1:0]  sel_out;
    logic [LEN-1:0]       cnt;

    logic                 q_nonempty;
    logic                 q_full;
    logic                 last_beat;
    logic                 beat;
    logic                 pop;
    logic                 push_ok;
    logic [DEPTHB+1:0]    full_sum;
    logic                 err_overflow;
    logic                 err_last;

    logic [INPUTS-1:0]    in_ready;
    logic [OUTPUTS-1:0]   out_valid;
    logic [OUTPUTS-1:0]   out_last;
    logic [DATA-1:0]      sel_data;
    logic [STRB-1:0]      sel_strb;

    assign q_nonempty = (count != '0);
    assign q_full     = (count == (DEPTHB+1)'(DEPTH));
    assign last_beat  = (cnt == '0);
    assign beat       = (state == XFER) && bus.in_valid[sel_in] && bus.out_ready[sel_out];

    // The next command loads on the same edge as the final beat, so bursts
    // run back to back without an idle cycle.
    assign pop     = q_nonempty && ((state == IDLE) || (beat && last_beat));
    // A pop in the same cycle frees the head slot, so a full queue can still accept.
    assign push_ok = bus.cmd_push && (!q_full || pop);

    // One slot of headroom covers the command stage's registered push.
    assign full_sum     = (DEPTHB+2)'(count) + (DEPTHB+2)'(bus.cmd_push);
    assign bus.cmd_full = (full_sum >= (DEPTHB+2)'(DEPTH));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (q_nonempty) state_next = XFER;
            XFER:    if (beat && last_beat && !q_nonempty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sel_in       <= '0;
            sel_out      <= '0;
            cnt          <= '0;
            err_overflow <= 1'b0;
            err_last     <= 1'b0;
        end else begin
            state <= state_next;
            if (push_ok) wr_ptr <= wr_ptr + DEPTHB'(1);
            if (pop)     rd_ptr <= rd_ptr + DEPTHB'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (DEPTHB+1)'(1);
                2'b01:   count <= count - (DEPTHB+1)'(1);
                default: count <= count;
            endcase
            if (pop) begin
                sel_in  <= q_in[rd_ptr];
                sel_out <= q_out[rd_ptr];
                cnt     <= q_len[rd_ptr];
            end else if (beat && !last_beat) begin
                cnt <= cnt - LEN'(1);
            end
            if (bus.cmd_push && q_full && !pop) err_overflow <= 1'b1;
            if (beat && (bus.in_last[sel_in] != last_beat)) err_last <= 1'b1;
        end
    end

    // Queue storage needs no reset; entries are only read behind count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_in[wr_ptr]  <= bus.cmd_input;
            q_out[wr_ptr] <= bus.cmd_output;
            q_len[wr_ptr] <= bus.cmd_len;
        end
    end

    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        out_last  = '0;
        if (state == XFER) begin
            in_ready[sel_in]   = bus.out_ready[sel_out];
            out_valid[sel_out] = bus.in_valid[sel_in];
            out_last[sel_out]  = last_beat;
        end
    end

    assign sel_data = bus.in_data[int'(sel_in)*DATA +: DATA];
    assign sel_strb = bus.in_strb[int'(sel_in)*STRB +: STRB];

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_last     = out_last;
    assign bus.out_data     = {OUTPUTS{sel_data}};
    assign bus.out_strb     = {OUTPUTS{sel_strb}};
    assign bus.err_overflow = err_overflow;
    assign bus.err_last     = err_last;
    assign bus.dbg_state    = (state == XFER);

endmodule

// File: tb/tb_dlsc_axi_router_wr_scheduler.sv
// Directed bench for the write-data scheduler: two inputs, two outputs,
// four-entry command queue.
module tb_dlsc_axi_router_wr_scheduler;

    localparam int DATA = 32, STRB = 4, LEN = 4;
    localparam int INPUTS = 2, INPUTSB = 1, OUTPUTS = 2, OUTPUTSB = 1;
    localparam int DEPTH = 4, DEPTHB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dlsc_axi_router_wr_scheduler_if #(
        .DATA(DATA), .STRB(STRB), .LEN(LEN), .INPUTS(INPUTS), .INPUTSB(INPUTSB),
        .OUTPUTS(OUTPUTS), .OUTPUTSB(OUTPUTSB)
    ) bus ();

    dlsc_axi_router_wr_scheduler #(
        .DATA(DATA), .STRB(STRB), .LEN(LEN), .INPUTS(INPUTS), .INPUTSB(INPUTSB),
        .OUTPUTS(OUTPUTS), .OUTPUTSB(OUTPUTSB), .DEPTH(DEPTH), .DEPTHB(DEPTHB)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA-1:0] exp_q[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus.cmd_push   = 1'b0;
        bus.cmd_input  = '0;
        bus.cmd_output = '0;
        bus.cmd_len    = '0;
        bus.in_valid   = '0;
        bus.in_last    = '0;
        bus.in_data    = '0;
        bus.in_strb    = '0;
        bus.out_ready  = 2'b11;
    endtask

    task automatic push(input logic i, input logic o, input logic [LEN-1:0] l);
        bus.cmd_push   = 1'b1;
        bus.cmd_input  = i;
        bus.cmd_output = o;
        bus.cmd_len    = l;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        settle();
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake got %b exp 0000", {bus.in_ready, bus.out_valid});
        end
        checks++;
        if ({bus.cmd_full, bus.err_overflow, bus.err_last, bus.dbg_state} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000",
                     {bus.cmd_full, bus.err_overflow, bus.err_last, bus.dbg_state});
        end
    endtask

    task automatic test_single();
        logic [DATA-1:0] d;
        logic [1:0] el;
        cyc();
        push(1'b1, 1'b0, 4'd3);
        settle();
        checks++;
        if (bus.cmd_full !== 1'b0) begin
            errors++;
            $display("FAIL single_full got %b exp 0", bus.cmd_full);
        end
        cyc();
        bus.cmd_push = 1'b0;
        bus.in_valid = 2'b10;
        settle();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL single_latency got %b exp 0000", {bus.out_valid, bus.in_ready});
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            d = 32'hA000 + i;
            bus.in_data = {d, 32'h0};
            bus.in_strb = {4'h5, 4'h0};
            bus.in_last = {(i == 3), 1'b0};
            el = (i == 3) ? 2'b01 : 2'b00;
            settle();
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_last} !== {2'b01, 2'b10, el}) begin
                errors++;
                $display("FAIL single_beat%0d got %b exp %b", i,
                         {bus.out_valid, bus.in_ready, bus.out_last}, {2'b01, 2'b10, el});
            end
            checks++;
            if ({bus.out_data, bus.out_strb} !== {d, d, 4'h5, 4'h5}) begin
                errors++;
                $display("FAIL single_data%0d got %h exp %h", i,
                         {bus.out_data, bus.out_strb}, {d, d, 4'h5, 4'h5});
            end
        end
        cyc();
        bus.in_valid = 2'b00;
        settle();
        checks++;
        if ({bus.dbg_state, bus.out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL single_end got %b exp 000", {bus.dbg_state, bus.out_valid});
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA-1:0] d;
        logic [5:0] eh [3];
        logic [DATA-1:0] ed [3];
        eh = '{6'b10_01_10, 6'b01_10_00, 6'b01_10_01};
        ed = '{32'hB0, 32'hC0, 32'hC1};
        cyc();
        push(1'b0, 1'b1, 4'd0);
        cyc();
        push(1'b1, 1'b0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.cmd_push = 1'b0;
            bus.in_valid = 2'b11;
            case (i)
                0: begin bus.in_data = {32'hB1, 32'hB0}; bus.in_last = 2'b01; end
                1: begin bus.in_data = {32'hC0, 32'h0};  bus.in_last = 2'b00; end
                default: begin bus.in_data = {32'hC1, 32'h0}; bus.in_last = 2'b10; end
            endcase
            settle();
            d = ed[i];
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_last} !== eh[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d got %b exp %b", i,
                         {bus.out_valid, bus.in_ready, bus.out_last}, eh[i]);
            end
            checks++;
            if (bus.out_data !== {d, d}) begin
                errors++;
                $display("FAIL b2b_data%0d got %h exp %h", i, bus.out_data, {d, d});
            end
        end
        cyc();
        bus.in_valid = 2'b00;
        settle();
        checks++;
        if (bus.dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got %b exp 0", bus.dbg_state);
        end
    endtask

    task automatic test_backpressure();
        logic [DATA-1:0] e;
        int k;
        int n;
        cyc();
        push(1'b0, 1'b1, 4'd7);
        cyc();
        bus.cmd_push = 1'b0;
        for (int j = 0; j < 8; j++) exp_q.push_back(32'hD000 + j);
        k = 0;
        n = 0;
        while (k < 8 && n < 100) begin
            cyc();
            n++;
            bus.in_valid  = {1'b0, 1'($urandom_range(0, 1))};
            bus.out_ready = {1'($urandom_range(0, 1)), 1'b1};
            bus.in_data   = {32'h0, 32'hD000 + k};
            bus.in_last   = {1'b0, (k == 7)};
            settle();
            checks++;
            if ({bus.out_valid, bus.in_ready} !== {bus.in_valid[0], 1'b0, 1'b0, bus.out_ready[1]}) begin
                errors++;
                $display("FAIL bp_handshake got %b exp %b", {bus.out_valid, bus.in_ready},
                         {bus.in_valid[0], 1'b0, 1'b0, bus.out_ready[1]});
            end
            if (bus.in_valid[0] && bus.out_ready[1]) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.out_data[63:32], bus.out_last} !== {e, (k == 7), 1'b0}) begin
                    errors++;
                    $display("FAIL bp_beat%0d got %h/%b exp %h/%b", k, bus.out_data[63:32],
                             bus.out_last, e, {(k == 7), 1'b0});
                end
                k++;
            end
        end
        checks++;
        if (k !== 8) begin
            errors++;
            $display("FAIL bp_count got %0d exp 8", k);
        end
        cyc();
        bus.in_valid  = 2'b00;
        bus.out_ready = 2'b11;
        settle();
        checks++;
        if (bus.dbg_state !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_end got state %b left %0d exp 0 0", bus.dbg_state, exp_q.size());
        end
    endtask

    task automatic test_fill();
        logic [1:0] routes [6];
        logic       exp_full [6];
        logic [1:0] exp_rdy [5];
        logic [1:0] exp_vld [5];
        logic [DATA-1:0] d;
        routes   = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
        exp_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        exp_vld  = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        bus.out_ready = 2'b00;
        for (int i = 0; i < 6; i++) begin
            cyc();
            push(routes[i][1], routes[i][0], 4'd0);
            settle();
            checks++;
            if (bus.cmd_full !== exp_full[i]) begin
                errors++;
                $display("FAIL fill_full%0d got %b exp %b", i, bus.cmd_full, exp_full[i]);
            end
        end
        cyc();
        bus.cmd_push = 1'b0;
        settle();
        checks++;
        if ({bus.err_overflow, bus.cmd_full} !== 2'b11) begin
            errors++;
            $display("FAIL fill_overflow got %b exp 11", {bus.err_overflow, bus.cmd_full});
        end
        for (int j = 0; j < 5; j++) begin
            cyc();
            bus.out_ready = 2'b11;
            bus.in_valid  = 2'b11;
            bus.in_last   = 2'b11;
            bus.in_data   = {32'hBBBB, 32'hAAAA};
            settle();
            d = exp_rdy[j][1] ? 32'hBBBB : 32'hAAAA;
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.out_data} !== {exp_rdy[j], exp_vld[j], d, d}) begin
                errors++;
                $display("FAIL fill_drain%0d got %h exp %h", j, {bus.in_ready, bus.out_valid, bus.out_data},
                         {exp_rdy[j], exp_vld[j], d, d});
            end
        end
        cyc();
        settle();
        checks++;
        if ({bus.dbg_state, bus.in_ready, bus.out_valid} !== 5'b00000) begin
            errors++;
            $display("FAIL fill_end got %b exp 00000", {bus.dbg_state, bus.in_ready, bus.out_valid});
        end
        bus.in_valid = 2'b00;
        bus.in_last  = 2'b00;
    endtask

    task automatic test_err_last();
        logic [DATA-1:0] d;
        cyc();
        push(1'b0, 1'b0, 4'd3);
        cyc();
        bus.cmd_push = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            d = 32'hE000 + i;
            bus.in_valid = 2'b01;
            bus.in_data  = {32'h0, d};
            bus.in_last  = {1'b0, (i == 1)};
            settle();
            checks++;
            if ({bus.out_last, bus.out_data} !== {1'b0, (i == 3), d, d}) begin
                errors++;
                $display("FAIL errl_beat%0d got %h exp %h", i, {bus.out_last, bus.out_data},
                         {1'b0, (i == 3), d, d});
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (bus.err_last !== (i == 2)) begin
                    errors++;
                    $display("FAIL errl_flag%0d got %b exp %b", i, bus.err_last, (i == 2));
                end
            end
        end
        cyc();
        bus.in_valid = 2'b00;
        bus.in_last  = 2'b00;
        settle();
        checks++;
        if ({bus.dbg_state, bus.err_last} !== 2'b01) begin
            errors++;
            $display("FAIL errl_end got %b exp 01", {bus.dbg_state, bus.err_last});
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA-1:0] d;
        cyc(); push(1'b1, 1'b1, 4'd5);
        cyc(); push(1'b0, 1'b0, 4'd0);
        cyc(); push(1'b1, 1'b0, 4'd0);
        cyc(); push(1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            bus.cmd_push = 1'b0;
            bus.in_valid = 2'b10;
            bus.in_data  = {32'hF000 + i, 32'h0};
            rst = (i == 1);
            settle();
            checks++;
            if ({bus.out_valid, bus.out_last} !== 4'b1000) begin
                errors++;
                $display("FAIL rmid_beat%0d got %b exp 1000", i, {bus.out_valid, bus.out_last});
            end
        end
        cyc();
        rst = 1'b0;
        bus.in_valid = 2'b11;
        settle();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.cmd_full, bus.err_overflow, bus.err_last, bus.dbg_state}
            !== 8'b0) begin
            errors++;
            $display("FAIL rmid_after got %b exp 00000000",
                     {bus.out_valid, bus.in_ready, bus.cmd_full, bus.err_overflow, bus.err_last, bus.dbg_state});
        end
        cyc();
        settle();
        checks++;
        if ({bus.out_valid, bus.dbg_state} !== 3'b000) begin
            errors++;
            $display("FAIL rmid_flushed got %b exp 000", {bus.out_valid, bus.dbg_state});
        end
        cyc();
        push(1'b0, 1'b1, 4'd1);
        cyc();
        bus.cmd_push = 1'b0;
        settle();
        checks++;
        if (bus.out_valid !== 2'b00) begin
            errors++;
            $display("FAIL rmid_wait got %b exp 00", bus.out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            d = 32'h6000 + i;
            bus.in_data = {32'h0, d};
            bus.in_last = {1'b0, (i == 1)};
            settle();
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_last, bus.out_data} !==
                {2'b10, 2'b01, (i == 1), 1'b0, d, d}) begin
                errors++;
                $display("FAIL rmid_new%0d got %h exp %h", i,
                         {bus.out_valid, bus.in_ready, bus.out_last, bus.out_data},
                         {2'b10, 2'b01, (i == 1), 1'b0, d, d});
            end
        end
        cyc();
        bus.in_valid = 2'b00;
        settle();
        checks++;
        if ({bus.dbg_state, bus.err_last, bus.err_overflow} !== 3'b000) begin
            errors++;
            $display("FAIL rmid_end got %b exp 000", {bus.dbg_state, bus.err_last, bus.err_overflow});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_fill();
        test_err_last();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlsc_axi_router_wr_scheduler.md
Name: dlsc_axi_router_wr_scheduler

Overview:
Write-data channel scheduler for the AXI router. It queues routing commands (input index, output index, burst length) from the router command stage in issue order. It then steers W beats from the selected input port to the selected output port, one burst at a time. It regenerates WLAST from the burst length and reports queue occupancy back to the command stage as backpressure.

Parameters:
DATA, 32, W data width in bits
STRB, DATA/8, W strobe width
LEN, 4, burst length field width (beats = len+1)
INPUTS, 1, number of input ports
INPUTSB, 1, index width for inputs (>= clog2(INPUTS), min 1)
OUTPUTS, 1, number of output ports
OUTPUTSB, 1, index width for outputs (>= clog2(OUTPUTS), min 1)
DEPTH, 16, command queue depth (power of 2, >= 2)
DEPTHB, 4, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_push  in  1  enqueue command this cycle
cmd_input  in  INPUTSB  source input index
cmd_output  in  OUTPUTSB  destination output index
cmd_len  in  LEN  burst length minus one
cmd_full  out  1  queue cannot accept a command issued next cycle
in_ready  out  INPUTS  W ready per input
in_valid  in  INPUTS  W valid per input
in_last  in  INPUTS  W last per input (checked only)
in_data  in  INPUTS*DATA  W data, packed
in_strb  in  INPUTS*STRB  W strobe, packed
out_ready  in  OUTPUTS  W ready per output
out_valid  out  OUTPUTS  W valid per output
out_last  out  OUTPUTS  W last per output (regenerated)
out_data  out  OUTPUTS*DATA  W data; same selected beat replicated to every output
out_strb  out  OUTPUTS*STRB  W strobe, replicated
err_overflow  out  1  sticky: cmd_push while queue held DEPTH entries
err_last  out  1  sticky: in_last disagreed with computed last on an accepted beat

Behaviour:
- Reset: queue empty, count=0, state IDLE, err_* = 0. Next cycle: in_ready=0, out_valid=0, cmd_full=0.
- Queue: circular FIFO, DEPTH entries of {input, output, len}, write/read pointers DEPTHB bits wrapping modulo DEPTH, count DEPTHB+1 bits.
- Push when cmd_push=1 and count<DEPTH.
- Push when count==DEPTH: command dropped, err_overflow<=1, queue unchanged.
- cmd_full is combinational: (count + cmd_push) >= DEPTH. This gives one slot of headroom for the command stage's registered push, so a cmd_full=0 observation always leads to a push that fits.
- States: IDLE, XFER.
- IDLE: if count>0, pop the head into the active registers (sel_in, sel_out, beat counter cnt=len), then go to XFER. The pop happens at the same edge.
- XFER transfer rules:
  - in_ready[sel_in] = out_ready[sel_out]; out_valid[sel_out] = in_valid[sel_in].
  - All other in_ready and out_valid bits are 0.
  - out_data and out_strb carry the sel_in slice.
  - out_last[sel_out] = (cnt==0); other out_last bits are 0.
- Beat accepted (in_valid&&out_ready on the selected pair):
  - If cnt!=0: cnt decrements.
  - If cnt==0 and count>0: the next command is popped at the same edge and the state stays XFER. There is no bubble between bursts.
  - If cnt==0 and count==0: go to IDLE.
- Whenever a beat is accepted and in_last[sel_in] != (cnt==0), err_last<=1. The forwarded beat still follows the counter; the input's last flag is never used for sequencing.
- Push and pop in the same cycle: count unchanged and both pointers advance. This is legal at count==DEPTH (pop frees the slot first). No overflow is flagged in that case.
- Latency: cmd_push asserted in cycle N (queue empty, IDLE) → XFER from cycle N+2. The first beat can be accepted in N+2.
- All ports not selected see ready/valid=0. Their beats stall indefinitely without error.
- out_valid may depend combinationally on in_valid, and in_ready on out_ready. There are no registers in the data path.
- err_* clear only on rst.
- rst in mid-burst: the burst is abandoned, the queue is flushed, and outputs idle on the next cycle.

Test Plan:
1. Single command {in=1, out=0, len=3}, both sides always ready → 4 beats forwarded on cycles N+2..N+5, out_last[0]=1 only on the 4th, in_ready[0]=0 throughout.
2. Two queued commands {0→1, len=0} and {1→0, len=1} → beat on output 1 with last=1, then immediately next cycle beats from input 1 on output 0, no idle cycle; out_last asserted on beat 2.
3. Backpressure: random out_ready/in_valid toggling during len=7 burst → exactly 8 beats, data order preserved, no duplicates, cnt holds while stalled.
4. Fill queue (DEPTH=4) with push every cycle, no W traffic → cmd_full=1 once count+cmd_push>=4. A forced push at count=4 sets err_overflow=1 and does not corrupt queued entries.
5. in_last asserted on beat 2 of a len=3 burst → err_last=1, burst still completes 4 beats with out_last on beat 4.
6. Assert rst on beat 2 of a len=5 burst with 3 queued commands → next cycle all out_valid/in_ready=0, cmd_full=0, err_*=0; a new command then executes normally.
